branch_control_unit: RTL and testbench

BRANCH_CONTROL_UNIT -- requirements
Module: branch_control_unit

---
 rtl/branch_control_unit.sv | 175 +++++++++++++++++
 tb/tb_branch_control_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_control_unit.sv
// Branch control unit: decodes control-transfer instructions from a
// synchronous-read instruction memory, steers the fetch stage, squashes the
// single wrong-path instruction after a taken transfer and maintains a
// 4-entry return address stack with sticky overflow/underflow flags.
module branch_control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pc,
    input  logic [9:0] instr,
    input  logic       zero_flag,
    input  logic       stall,
    output logic [1:0] fetch_control,
    output logic [7:0] jump_addr,
    output logic [9:0] ra_addr,
    output logic       squash,
    output logic       ras_overflow,
    output logic       ras_underflow
);

    localparam int RAS_DEPTH = 4;

    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_BEQZ = 4'b1101;
    localparam logic [3:0] OP_CALL = 4'b1110;
    localparam logic [3:0] OP_RET  = 4'b1111;

    localparam logic [1:0] FC_NEXT = 2'b00;
    localparam logic [1:0] FC_JUMP = 2'b01;
    localparam logic [1:0] FC_RET  = 2'b10;
    localparam logic [1:0] FC_HOLD = 2'b11;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic [9:0] ipc_reg;
    logic [9:0] stack_reg  [RAS_DEPTH];
    logic [9:0] stack_next [RAS_DEPTH];
    logic [9:0] push_val   [RAS_DEPTH];
    logic [9:0] pop_val    [RAS_DEPTH];
    logic [2:0] count_reg;
    logic [2:0] count_next;
    logic       ovf_reg;
    logic       ovf_next;
    logic       unf_reg;
    logic       unf_next;

    logic [3:0] opcode;
    logic       is_jmp;
    logic       is_beqz;
    logic       is_call;
    logic       is_ret;
    logic       stack_empty;
    logic       stack_full;
    logic       in_run;
    logic       take_jump;
    logic       take_ret;
    logic       do_push;
    logic       do_pop;
    logic [9:0] ret_link;

    assign opcode      = instr[9:6];
    assign is_jmp      = (opcode == OP_JMP);
    assign is_beqz     = (opcode == OP_BEQZ);
    assign is_call     = (opcode == OP_CALL);
    assign is_ret      = (opcode == OP_RET);
    assign stack_empty = (count_reg == 3'd0);
    assign stack_full  = (count_reg == 3'd4);

    // Decode is only trusted in RUN and outside reset; SQUASH marks instr invalid.
    assign in_run    = (state_reg == ST_RUN) && !reset;
    assign take_jump = in_run && (is_jmp || (is_beqz && zero_flag) || is_call);
    assign take_ret  = in_run && is_ret && !stack_empty;

    // Stack updates also wait for a non-stalled edge.
    assign do_push  = take_jump && is_call && !stall;
    assign do_pop   = take_ret && !stall;
    assign ret_link = ipc_reg + 10'd1;

    // Entry 0 is the top; a push shifts everything down (oldest falls off the
    // bottom when full), a pop shifts up and back-fills zero.
    generate
        for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_shift
            if (gi == 0) begin : g_top
                assign push_val[gi] = ret_link;
            end else begin : g_below
                assign push_val[gi] = stack_reg[gi-1];
            end
            if (gi == RAS_DEPTH - 1) begin : g_bottom
                assign pop_val[gi] = 10'd0;
            end else begin : g_above
                assign pop_val[gi] = stack_reg[gi+1];
            end
            assign stack_next[gi] = do_push ? push_val[gi] :
                                    do_pop  ? pop_val[gi]  :
                                              stack_reg[gi];
        end
    endgenerate

    // Next-state, occupancy and sticky flag computation.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        ovf_next   = ovf_reg;
        unf_next   = unf_reg;
        if (!stall) begin
            if (state_reg == ST_SQUASH) begin
                state_next = ST_RUN;
            end else begin
                if (take_jump || take_ret) begin
                    state_next = ST_SQUASH;
                end
                if (do_push) begin
                    if (stack_full) begin
                        ovf_next = 1'b1;
                    end else begin
                        count_next = count_reg + 3'd1;
                    end
                end
                if (do_pop) begin
                    count_next = count_reg - 3'd1;
                end
                if (is_ret && stack_empty) begin
                    unf_next = 1'b1;
                end
            end
        end
    end

    // State registers; reset wins over stall, stall freezes everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_SQUASH;
            ipc_reg   <= 10'd0;
            count_reg <= 3'd0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                stack_reg[i] <= 10'd0;
            end
        end else if (!stall) begin
            state_reg <= state_next;
            ipc_reg   <= pc;
            count_reg <= count_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                stack_reg[i] <= stack_next[i];
            end
        end
    end

    // Redirect select is combinational so fetch reacts at the same edge.
    always_comb begin
        if (stall) begin
            fetch_control = FC_HOLD;
        end else if (take_jump) begin
            fetch_control = FC_JUMP;
        end else if (take_ret) begin
            fetch_control = FC_RET;
        end else begin
            fetch_control = FC_NEXT;
        end
    end

    assign jump_addr     = {2'b00, instr[5:0]};
    assign ra_addr       = (reset || stack_empty) ? 10'd0 : stack_reg[0];
    assign squash        = reset || (state_reg == ST_SQUASH);
    assign ras_overflow  = ovf_reg;
    assign ras_underflow = unf_reg;

endmodule

// File: tb/tb_branch_control_unit.sv
// Testbench for branch_control_unit: directed scenarios followed by random
// traffic, all checked against a queue-based behavioural model.
module tb_branch_control_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] pc = 10'd0;
    logic [9:0] instr = 10'd0;
    logic       zero_flag = 1'b0;
    logic       stall = 1'b0;
    logic [1:0] fetch_control;
    logic [7:0] jump_addr;
    logic [9:0] ra_addr;
    logic       squash;
    logic       ras_overflow;
    logic       ras_underflow;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    logic [9:0] m_stack [$];
    bit         m_sq = 1'b1;
    logic [9:0] m_ipc = 10'd0;
    bit         m_ov = 1'b0;
    bit         m_un = 1'b0;
    bit         primed = 1'b0;

    // Last observed outputs, for scenario-specific checks
    logic [1:0] last_fc;
    logic [7:0] last_ja;
    logic [9:0] last_ra;
    logic       last_sq;
    logic [9:0] last_target;

    localparam logic [9:0] NOP  = 10'b0000_000000;
    localparam logic [3:0] JMP  = 4'hC;
    localparam logic [3:0] BEQZ = 4'hD;
    localparam logic [3:0] CALL = 4'hE;
    localparam logic [3:0] RET  = 4'hF;

    branch_control_unit dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .instr         (instr),
        .zero_flag     (zero_flag),
        .stall         (stall),
        .fetch_control (fetch_control),
        .jump_addr     (jump_addr),
        .ra_addr       (ra_addr),
        .squash        (squash),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] mk(input logic [3:0] op, input int off);
        logic [5:0] o;
        o = off[5:0];
        return {op, o};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then
    // advance the model as the rising edge will advance the DUT.
    task automatic step(input logic [9:0] p, input logic [9:0] ins, input logic zf,
                        input logic st, input logic rst);
        logic [3:0] op;
        logic [1:0] e_fc;
        logic [9:0] e_ra;
        logic       e_sq;
        logic [9:0] off;
        @(negedge clk);
        pc = p; instr = ins; zero_flag = zf; stall = st; reset = rst;
        #1;
        op  = ins[9:6];
        off = {4'b0000, ins[5:0]};
        e_sq = rst || m_sq;
        if (st)                                            e_fc = 2'b11;
        else if (e_sq)                                     e_fc = 2'b00;
        else if (op == JMP || op == CALL || (op == BEQZ && zf)) e_fc = 2'b01;
        else if (op == RET && m_stack.size() > 0)          e_fc = 2'b10;
        else                                               e_fc = 2'b00;
        e_ra = (rst || m_stack.size() == 0) ? 10'd0 : m_stack[0];

        check("fetch_control", {30'd0, fetch_control}, {30'd0, e_fc});
        check("jump_addr", {24'd0, jump_addr}, {22'd0, off});
        check("ra_addr", {22'd0, ra_addr}, {22'd0, e_ra});
        check("squash", {31'd0, squash}, {31'd0, e_sq});
        if (primed) begin
            check("ras_overflow", {31'd0, ras_overflow}, {31'd0, m_ov});
            check("ras_underflow", {31'd0, ras_underflow}, {31'd0, m_un});
        end
        last_target = dut.ipc_reg + 10'd1 + {4'b0000, jump_addr[5:0]};
        if (primed && e_fc == 2'b01) begin
            check("target", {22'd0, last_target}, {22'd0, 10'(m_ipc + 10'd1 + off)});
        end
        last_fc = fetch_control; last_ja = jump_addr; last_ra = ra_addr; last_sq = squash;

        if (rst) begin
            m_stack.delete();
            m_sq = 1'b1; m_ipc = 10'd0; m_ov = 1'b0; m_un = 1'b0;
            primed = 1'b1;
        end else if (!st) begin
            if (m_sq) begin
                m_sq = 1'b0;
            end else begin
                case (op)
                    JMP:  m_sq = 1'b1;
                    BEQZ: if (zf) m_sq = 1'b1;
                    CALL: begin
                        if (m_stack.size() == 4) begin
                            void'(m_stack.pop_back());
                            m_ov = 1'b1;
                        end
                        m_stack.push_front(10'(m_ipc + 10'd1));
                        m_sq = 1'b1;
                    end
                    RET: begin
                        if (m_stack.size() > 0) begin
                            void'(m_stack.pop_front());
                            m_sq = 1'b1;
                        end else begin
                            m_un = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            m_ipc = p;
        end
        @(posedge clk);
    endtask

    initial begin
        // Reset, then release with a non-control instruction
        step(10'd0, NOP, 1'b0, 1'b0, 1'b1);
        step(10'd0, NOP, 1'b0, 1'b0, 1'b1);
        check("rst_ra", {22'd0, last_ra}, 32'd0);
        step(10'd1, NOP, 1'b0, 1'b0, 1'b0);
        check("rel_c1_sq", {31'd0, last_sq}, 32'd1);
        check("rel_c1_fc", {30'd0, last_fc}, 32'd0);
        step(10'd20, NOP, 1'b0, 1'b0, 1'b0);
        check("rel_c2_sq", {31'd0, last_sq}, 32'd0);
        check("rel_c2_fc", {30'd0, last_fc}, 32'd0);

        // JMP +5 at ipc 20, wrong-path CALL ignored
        step(10'd26, mk(JMP, 5), 1'b0, 1'b0, 1'b0);
        check("jmp_fc", {30'd0, last_fc}, 32'd1);
        check("jmp_ja", {24'd0, last_ja}, 32'd5);
        check("jmp_target", {22'd0, last_target}, 32'd26);
        step(10'd50, mk(CALL, 7), 1'b0, 1'b0, 1'b0);
        check("jmp_wp_sq", {31'd0, last_sq}, 32'd1);
        check("jmp_wp_fc", {30'd0, last_fc}, 32'd0);

        // BEQZ not taken then taken
        step(10'd51, mk(BEQZ, 3), 1'b0, 1'b0, 1'b0);
        check("beqz_nt_fc", {30'd0, last_fc}, 32'd0);
        step(10'd52, mk(BEQZ, 3), 1'b1, 1'b0, 1'b0);
        check("beqz_nt_sq", {31'd0, last_sq}, 32'd0);
        check("beqz_t_fc", {30'd0, last_fc}, 32'd1);
        step(10'd100, NOP, 1'b0, 1'b0, 1'b0);
        check("beqz_t_sq", {31'd0, last_sq}, 32'd1);

        // CALL at ipc 100, RET later
        step(10'd0, mk(CALL, 9), 1'b0, 1'b0, 1'b0);
        check("call_fc", {30'd0, last_fc}, 32'd1);
        step(10'd110, NOP, 1'b0, 1'b0, 1'b0);
        step(10'd111, NOP, 1'b0, 1'b0, 1'b0);
        check("call_ra", {22'd0, last_ra}, 32'd101);
        step(10'd101, mk(RET, 0), 1'b0, 1'b0, 1'b0);
        check("ret_fc", {30'd0, last_fc}, 32'd2);
        check("ret_ra", {22'd0, last_ra}, 32'd101);
        step(10'd1, NOP, 1'b0, 1'b0, 1'b0);
        check("ret_empty_ra", {22'd0, last_ra}, 32'd0);

        // Five CALLs at ipc 1,3,5,7,9 (ipc 1 set by previous squashed step)
        for (int k = 0; k < 5; k++) begin
            step(10'd0, mk(CALL, 1), 1'b0, 1'b0, 1'b0);
            step(10'(2 * k + 3), NOP, 1'b0, 1'b0, 1'b0);
        end
        step(10'd200, NOP, 1'b0, 1'b0, 1'b0);
        check("ovf_flag", {31'd0, ras_overflow}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            step(10'd0, mk(RET, 0), 1'b0, 1'b0, 1'b0);
            check("ovf_ret_ra", {22'd0, last_ra}, 32'(10 - 2 * k));
            step(10'd200, NOP, 1'b0, 1'b0, 1'b0);
        end
        step(10'd201, mk(RET, 0), 1'b0, 1'b0, 1'b0);
        check("unf_fc", {30'd0, last_fc}, 32'd0);
        step(10'd200, NOP, 1'b0, 1'b0, 1'b0);
        check("unf_flag", {31'd0, ras_underflow}, 32'd1);
        check("unf_nosq", {31'd0, last_sq}, 32'd0);

        // Stall during CALL at ipc 200, then release
        step(10'd0, mk(CALL, 2), 1'b0, 1'b1, 1'b0);
        check("stall_fc", {30'd0, last_fc}, 32'd3);
        step(10'd0, mk(CALL, 2), 1'b0, 1'b1, 1'b0);
        check("stall_ra", {22'd0, last_ra}, 32'd0);
        step(10'd300, mk(CALL, 2), 1'b0, 1'b0, 1'b0);
        check("unstall_fc", {30'd0, last_fc}, 32'd1);
        step(10'd301, NOP, 1'b0, 1'b0, 1'b0);
        check("unstall_ra", {22'd0, last_ra}, 32'd201);

        // Wrap: ipc 0x3FF, JMP +2
        step(10'h3FF, NOP, 1'b0, 1'b0, 1'b0);
        step(10'd0, mk(JMP, 2), 1'b0, 1'b0, 1'b0);
        check("wrap_target", {22'd0, last_target}, 32'd2);

        // Reset mid-SQUASH with non-empty stack
        step(10'd5, NOP, 1'b0, 1'b0, 1'b1);
        step(10'd6, NOP, 1'b0, 1'b0, 1'b0);
        check("midrst_ra", {22'd0, last_ra}, 32'd0);
        check("midrst_sq", {31'd0, last_sq}, 32'd1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            logic [3:0] op;
            int r;
            r = $urandom_range(0, 9);
            op = (r < 6) ? 4'(12 + (r % 4)) : 4'($urandom_range(0, 11));
            step(10'($urandom), {op, 6'($urandom)}, 1'($urandom),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 49) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
